// File: rtl/grf_arb_pkg.sv
// Shared types and constants for the GRF write arbiter and its port-1 write queue.
package grf_arb_pkg;

    localparam int ARB_DEPTH  = 2;
    localparam int REG_ADDR_W = 5;
    localparam int ARB_CNT_W  = $clog2(ARB_DEPTH + 1);
    localparam int ARB_PTR_W  = $clog2(ARB_DEPTH);
    localparam int WAIT_W     = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [31:0]           data;
        logic [31:0]           pc;
    } wr_entry_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        P0   = 2'd1,
        P1   = 2'd2
    } grant_src_e;

    function automatic logic [31:0] addr_onehot(input logic [REG_ADDR_W-1:0] a);
        return 32'(1) << a;
    endfunction

endpackage

// File: rtl/grf_arb_fifo.sv
// In-order 2-entry queue for port-1 (mul/div) register writes.
// With GRF_ARB_SCOREBOARD_EN defined it also exposes per-slot address/occupancy.
module grf_arb_fifo
    import grf_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  wr_entry_t             push_entry_i,
    input  logic                  pop_i,
`ifdef GRF_ARB_SCOREBOARD_EN
    output logic [REG_ADDR_W-1:0] slot_addr_o [ARB_DEPTH],
    output logic [ARB_DEPTH-1:0]  slot_vld_o,
`endif
    output logic [ARB_CNT_W-1:0]  count_o,
    output wr_entry_t             head_o
);

    logic [ARB_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ARB_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ARB_CNT_W-1:0] count_q, count_d;
    wr_entry_t            mem_q [ARB_DEPTH];
    logic                 do_push;
    logic                 do_pop;

    assign do_push = push_i && (count_q < ARB_CNT_W'(ARB_DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

`ifdef GRF_ARB_SCOREBOARD_EN
    // A slot is live when its distance from the read pointer is below the fill count.
    always_comb begin
        logic [ARB_PTR_W-1:0] ofs;
        ofs = '0;
        for (int i = 0; i < ARB_DEPTH; i++) begin
            ofs            = ARB_PTR_W'(i) - rd_ptr_q;
            slot_addr_o[i] = mem_q[i].addr;
            slot_vld_o[i]  = (ARB_CNT_W'(ofs) < count_q);
        end
    end
`endif

endmodule

// File: rtl/grf_write_arbiter.sv
// Register-file write arbiter: pipeline writeback (port 0) has priority, queued mul/div
// writes (port 1) are forced after MAX_WAIT cycles. Macro GRF_ARB_SCOREBOARD_EN enables pending.
module grf_write_arbiter
    import grf_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic [REG_ADDR_W-1:0] p0_addr,
    input  logic [31:0]           p0_data,
    input  logic [31:0]           p0_pc,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic [REG_ADDR_W-1:0] p1_addr,
    input  logic [31:0]           p1_data,
    input  logic [31:0]           p1_pc,
    output logic                  grf_we,
    output logic [REG_ADDR_W-1:0] grf_a3,
    output logic [31:0]           grf_wd,
    output logic [31:0]           grf_wpc,
    output logic [31:0]           pending,
    output logic                  p1_starve
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    wr_entry_t             p1_entry;
    wr_entry_t             head;
    logic [ARB_CNT_W-1:0]  count;
    logic                  fifo_nonempty;
    logic                  force_grant;
    logic                  p0_req;
    logic                  push;
    logic                  pop;
    grant_src_e            grant;

    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  grf_we_q, grf_we_d;
    logic [REG_ADDR_W-1:0] grf_a3_q, grf_a3_d;
    logic [31:0]           grf_wd_q, grf_wd_d;
    logic [31:0]           grf_wpc_q, grf_wpc_d;

`ifdef GRF_ARB_SCOREBOARD_EN
    logic [REG_ADDR_W-1:0] slot_addr [ARB_DEPTH];
    logic [ARB_DEPTH-1:0]  slot_vld;
`endif

    assign p1_entry = '{addr: p1_addr, data: p1_data, pc: p1_pc};

    // Writes to r0 are acknowledged but never reach the queue or the register file.
    assign fifo_nonempty = (count != '0);
    assign p1_ready      = (count < ARB_CNT_W'(ARB_DEPTH));
    assign push          = p1_valid && p1_ready && (p1_addr != '0);
    assign p0_req        = p0_valid && (p0_addr != '0);
    assign force_grant   = fifo_nonempty && (wait_q == MAX_WAIT_C);
    assign p0_ready      = !force_grant;
    assign p1_starve     = force_grant;

    grf_arb_fifo u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (p1_entry),
        .pop_i        (pop),
`ifdef GRF_ARB_SCOREBOARD_EN
        .slot_addr_o  (slot_addr),
        .slot_vld_o   (slot_vld),
`endif
        .count_o      (count),
        .head_o       (head)
    );

    always_comb begin
        if (force_grant) begin
            grant = P1;
        end else if (p0_req) begin
            grant = P0;
        end else if (fifo_nonempty) begin
            grant = P1;
        end else begin
            grant = NONE;
        end
    end

    assign pop = (grant == P1);

    // Age of the queue head: saturates at MAX_WAIT, restarts whenever the head leaves.
    always_comb begin
        if (pop || !fifo_nonempty) begin
            wait_d = '0;
        end else if (wait_q == MAX_WAIT_C) begin
            wait_d = wait_q;
        end else begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_comb begin
        grf_we_d  = 1'b0;
        grf_a3_d  = grf_a3_q;
        grf_wd_d  = grf_wd_q;
        grf_wpc_d = grf_wpc_q;
        case (grant)
            P0: begin
                grf_we_d  = 1'b1;
                grf_a3_d  = p0_addr;
                grf_wd_d  = p0_data;
                grf_wpc_d = p0_pc;
            end
            P1: begin
                grf_we_d  = 1'b1;
                grf_a3_d  = head.addr;
                grf_wd_d  = head.data;
                grf_wpc_d = head.pc;
            end
            default: begin
                grf_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q    <= '0;
            grf_we_q  <= 1'b0;
            grf_a3_q  <= '0;
            grf_wd_q  <= '0;
            grf_wpc_q <= '0;
        end else begin
            wait_q    <= wait_d;
            grf_we_q  <= grf_we_d;
            grf_a3_q  <= grf_a3_d;
            grf_wd_q  <= grf_wd_d;
            grf_wpc_q <= grf_wpc_d;
        end
    end

    assign grf_we  = grf_we_q;
    assign grf_a3  = grf_a3_q;
    assign grf_wd  = grf_wd_q;
    assign grf_wpc = grf_wpc_q;

`ifdef GRF_ARB_SCOREBOARD_EN
    always_comb begin
        pending = '0;
        for (int i = 0; i < ARB_DEPTH; i++) begin
            if (slot_vld[i]) begin
                pending = pending | addr_onehot(slot_addr[i]);
            end
        end
    end
`else
    assign pending = '0;
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Bench for grf_write_arbiter: directed vector table, hand sequences, and randomized run
// against a queue-based reference model.
module tb_grf_write_arbiter;

    localparam int MW = 4;
`ifdef GRF_ARB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        p0_valid, p0_ready;
    logic [4:0]  p0_addr;
    logic [31:0] p0_data, p0_pc;
    logic        p1_valid, p1_ready;
    logic [4:0]  p1_addr;
    logic [31:0] p1_data, p1_pc;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_wpc;
    logic [31:0] pending;
    logic        p1_starve;

    grf_write_arbiter #(.MAX_WAIT(MW)) dut (
        .clk       (clk),
        .reset     (reset),
        .p0_valid  (p0_valid),
        .p0_ready  (p0_ready),
        .p0_addr   (p0_addr),
        .p0_data   (p0_data),
        .p0_pc     (p0_pc),
        .p1_valid  (p1_valid),
        .p1_ready  (p1_ready),
        .p1_addr   (p1_addr),
        .p1_data   (p1_data),
        .p1_pc     (p1_pc),
        .grf_we    (grf_we),
        .grf_a3    (grf_a3),
        .grf_wd    (grf_wd),
        .grf_wpc   (grf_wpc),
        .pending   (pending),
        .p1_starve (p1_starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    int          m_wait;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd, e_wpc;

    task automatic model_clear();
        m_q.delete();
        m_wait = 0;
        e_we = 1'b0; e_a3 = '0; e_wd = '0; e_wpc = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit   nonempty, frc, rdy1, p0r, popped;
        ent_t h, n;
        if (!reset) begin
            model_clear();
            return;
        end
        nonempty = (m_q.size() != 0);
        frc      = nonempty && (m_wait == MW);
        rdy1     = (m_q.size() < 2);
        p0r      = p0_valid && (p0_addr != 5'd0);
        popped   = 1'b0;
        e_we     = 1'b0;
        if (frc || (!p0r && nonempty)) begin
            h = m_q.pop_front();
            e_we = 1'b1; e_a3 = h.a; e_wd = h.d; e_wpc = h.pc;
            popped = 1'b1;
        end else if (p0r) begin
            e_we = 1'b1; e_a3 = p0_addr; e_wd = p0_data; e_wpc = p0_pc;
        end
        if (popped) m_wait = 0;
        else if (nonempty) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
        if (p1_valid && rdy1 && (p1_addr != 5'd0)) begin
            n.a = p1_addr; n.d = p1_data; n.pc = p1_pc;
            m_q.push_back(n);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] pend;
        logic        frc;
        if (!reset) model_clear();
        pend = '0;
        if (SB_EN) foreach (m_q[i]) pend[m_q[i].a] = 1'b1;
        frc = (m_q.size() != 0) && (m_wait == MW);
        chk({tag, ".we"},      32'(grf_we),    32'(e_we));
        chk({tag, ".a3"},      32'(grf_a3),    32'(e_a3));
        chk({tag, ".wd"},      grf_wd,         e_wd);
        chk({tag, ".wpc"},     grf_wpc,        e_wpc);
        chk({tag, ".p0_rdy"},  32'(p0_ready),  32'(!frc));
        chk({tag, ".p1_rdy"},  32'(p1_ready),  32'(m_q.size() < 2));
        chk({tag, ".starve"},  32'(p1_starve), 32'(frc));
        chk({tag, ".pending"}, pending,        pend);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".we"},      32'(grf_we),    32'd0);
        chk({tag, ".a3"},      32'(grf_a3),    32'd0);
        chk({tag, ".wd"},      grf_wd,         32'd0);
        chk({tag, ".wpc"},     grf_wpc,        32'd0);
        chk({tag, ".pending"}, pending,        32'd0);
        chk({tag, ".starve"},  32'(p1_starve), 32'd0);
        chk({tag, ".p1_rdy"},  32'(p1_ready),  32'd1);
        chk({tag, ".p0_rdy"},  32'(p0_ready),  32'd1);
    endtask

    task automatic next_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        p0v; logic [4:0] p0a; logic [31:0] p0d; logic [31:0] p0pc;
        logic        p1v; logic [4:0] p1a; logic [31:0] p1d; logic [31:0] p1pc;
        logic        we;  logic [4:0] a3;  logic [31:0] wd;  logic [31:0] wpc;
        logic        p0r; logic p1r; logic st; logic [31:0] pend;
    } vec_t;

    function automatic vec_t mk(
        input logic p0v, input logic [4:0] p0a, input logic [31:0] p0d, input logic [31:0] p0pc,
        input logic p1v, input logic [4:0] p1a, input logic [31:0] p1d, input logic [31:0] p1pc,
        input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] wpc,
        input logic p0r, input logic p1r, input logic st, input logic [31:0] pend);
        vec_t v;
        v.p0v = p0v; v.p0a = p0a; v.p0d = p0d; v.p0pc = p0pc;
        v.p1v = p1v; v.p1a = p1a; v.p1d = p1d; v.p1pc = p1pc;
        v.we = we; v.a3 = a3; v.wd = wd; v.wpc = wpc;
        v.p0r = p0r; v.p1r = p1r; v.st = st; v.pend = pend;
        return v;
    endfunction

    vec_t tbl [15];

    initial begin
        int   n_blk;
        bit   burst;
        vec_t v;

        // Expected columns describe what is visible while that row's inputs are applied.
        tbl[0]  = mk(1, 5, 32'h1234, 32'h3000, 0, 0, 0, 0,             0, 0, 32'h0,    32'h0,    1, 1, 0, 32'h0);
        tbl[1]  = mk(0, 0, 0, 0,               0, 0, 0, 0,             1, 5, 32'h1234, 32'h3000, 1, 1, 0, 32'h0);
        tbl[2]  = mk(0, 0, 0, 0,               1, 7, 32'hAA, 32'h4000, 0, 5, 32'h1234, 32'h3000, 1, 1, 0, 32'h0);
        tbl[3]  = mk(0, 0, 0, 0,               0, 0, 0, 0,             0, 5, 32'h1234, 32'h3000, 1, 1, 0, 32'h80);
        tbl[4]  = mk(0, 0, 0, 0,               0, 0, 0, 0,             1, 7, 32'hAA,   32'h4000, 1, 1, 0, 32'h0);
        tbl[5]  = mk(1, 9, 32'h99, 32'h6000,   1, 3, 32'h33, 32'h5000, 0, 7, 32'hAA,   32'h4000, 1, 1, 0, 32'h0);
        tbl[6]  = mk(1, 9, 32'h99, 32'h6000,   0, 0, 0, 0,             1, 9, 32'h99,   32'h6000, 1, 1, 0, 32'h8);
        tbl[7]  = mk(1, 9, 32'h99, 32'h6000,   0, 0, 0, 0,             1, 9, 32'h99,   32'h6000, 1, 1, 0, 32'h8);
        tbl[8]  = mk(1, 9, 32'h99, 32'h6000,   0, 0, 0, 0,             1, 9, 32'h99,   32'h6000, 1, 1, 0, 32'h8);
        tbl[9]  = mk(1, 9, 32'h99, 32'h6000,   0, 0, 0, 0,             1, 9, 32'h99,   32'h6000, 1, 1, 0, 32'h8);
        tbl[10] = mk(1, 9, 32'h99, 32'h6000,   0, 0, 0, 0,             1, 9, 32'h99,   32'h6000, 0, 1, 1, 32'h8);
        tbl[11] = mk(1, 9, 32'h99, 32'h6000,   0, 0, 0, 0,             1, 3, 32'h33,   32'h5000, 1, 1, 0, 32'h0);
        tbl[12] = mk(0, 0, 0, 0,               0, 0, 0, 0,             1, 9, 32'h99,   32'h6000, 1, 1, 0, 32'h0);
        tbl[13] = mk(1, 0, 32'hDEAD, 32'h7000, 1, 0, 32'hBEEF, 32'h7004, 0, 9, 32'h99, 32'h6000, 1, 1, 0, 32'h0);
        tbl[14] = mk(0, 0, 0, 0,               0, 0, 0, 0,             0, 9, 32'h99,   32'h6000, 1, 1, 0, 32'h0);

        reset = 1'b0;
        p0_valid = 1'b0; p0_addr = '0; p0_data = '0; p0_pc = '0;
        p1_valid = 1'b0; p1_addr = '0; p1_data = '0; p1_pc = '0;
        model_clear();

        @(negedge clk);
        check_reset_vals("por");
        next_cycle();
        reset = 1'b1;

        for (int r = 0; r < 15; r++) begin
            v = tbl[r];
            p0_valid = v.p0v; p0_addr = v.p0a; p0_data = v.p0d; p0_pc = v.p0pc;
            p1_valid = v.p1v; p1_addr = v.p1a; p1_data = v.p1d; p1_pc = v.p1pc;
            @(negedge clk);
            chk($sformatf("row%0d.we", r),      32'(grf_we),    32'(v.we));
            chk($sformatf("row%0d.a3", r),      32'(grf_a3),    32'(v.a3));
            chk($sformatf("row%0d.wd", r),      grf_wd,         v.wd);
            chk($sformatf("row%0d.wpc", r),     grf_wpc,        v.wpc);
            chk($sformatf("row%0d.p0_rdy", r),  32'(p0_ready),  32'(v.p0r));
            chk($sformatf("row%0d.p1_rdy", r),  32'(p1_ready),  32'(v.p1r));
            chk($sformatf("row%0d.starve", r),  32'(p1_starve), 32'(v.st));
            chk($sformatf("row%0d.pending", r), pending,        SB_EN ? v.pend : 32'h0);
            next_cycle();
        end

        // Queue full while port 0 stays busy: third request must wait for a pop.
        p0_valid = 1'b1; p0_addr = 5'd10; p0_data = 32'hA0; p0_pc = 32'h8000;
        p1_valid = 1'b1; p1_addr = 5'd1; p1_data = 32'h11; p1_pc = 32'h9000;
        @(negedge clk); check_model("full_a"); chk("full_a.ready", 32'(p1_ready), 32'd1);
        next_cycle();
        p1_addr = 5'd2; p1_data = 32'h22; p1_pc = 32'h9004;
        @(negedge clk); check_model("full_b"); chk("full_b.ready", 32'(p1_ready), 32'd1);
        next_cycle();
        p1_addr = 5'd4; p1_data = 32'h44; p1_pc = 32'h9008;
        @(negedge clk); check_model("full_c"); chk("full_c.ready", 32'(p1_ready), 32'd0);
        n_blk = 0;
        for (int k = 0; k < 20 && p1_ready !== 1'b1; k++) begin
            n_blk++;
            next_cycle();
            @(negedge clk);
            check_model("full_wait");
        end
        chk("full.blocked_cycles", 32'(n_blk), 32'd4);
        next_cycle();
        p1_valid = 1'b0; p0_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); check_model("drain");
            next_cycle();
        end

        // Reset with two entries queued: nothing may be written after release.
        p0_valid = 1'b1; p0_addr = 5'd10;
        p1_valid = 1'b1; p1_addr = 5'd12; p1_data = 32'hC0; p1_pc = 32'hA000;
        @(negedge clk); check_model("rq_a"); next_cycle();
        p1_addr = 5'd13; p1_data = 32'hD0; p1_pc = 32'hA004;
        @(negedge clk); check_model("rq_b"); next_cycle();
        p1_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk); check_reset_vals("rst_mid");
        next_cycle();
        @(negedge clk); check_reset_vals("rst_hold");
        next_cycle();
        reset = 1'b1; p0_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst.we", 32'(grf_we), 32'd0);
            check_model("post_rst");
            next_cycle();
        end

        // Randomized traffic with bursty port-0 load and narrow address range.
        burst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) burst = !burst;
            reset    = ($urandom_range(0, 149) != 0);
            p0_valid = burst ? 1'b1 : ($urandom_range(0, 1) == 1);
            p0_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            p0_data  = $urandom;
            p0_pc    = $urandom;
            p1_valid = ($urandom_range(0, 2) != 0);
            p1_addr  = 5'($urandom_range(0, 4));
            p1_data  = $urandom;
            p1_pc    = $urandom;
            @(negedge clk);
            check_model("rnd");
            next_cycle();
            reset = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/grf_write_arbiter.md
GRF_WRITE_ARBITER -- requirements
Module: grf_write_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, the number of cycles a queued port-1 write may wait before it is forced (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port p0_valid, input, 1 bit: pipeline writeback request.
REQ-005 SHALL have port p0_ready, output, 1 bit: port-0 request accepted this cycle.
REQ-006 SHALL have ports p0_addr (input, 5), p0_data (input, 32) and p0_pc (input, 32): port-0 destination register, write data and instruction PC.
REQ-007 SHALL have port p1_valid, input, 1 bit: mul/div-unit writeback request.
REQ-008 SHALL have port p1_ready, output, 1 bit: port-1 queue can accept.
REQ-009 SHALL have ports p1_addr (input, 5), p1_data (input, 32) and p1_pc (input, 32): port-1 destination, data and PC.
REQ-010 SHALL have ports grf_we (output, 1), grf_a3 (output, 5), grf_wd (output, 32) and grf_wpc (output, 32): registered register-file write port.
REQ-011 SHALL have port pending, output, 32 bits: bit n set while any queued port-1 write targets register n.
REQ-012 SHALL have port p1_starve, output, 1 bit: forced port-1 grant in progress this cycle.

Function
REQ-013 SHALL hold port-1 requests in a 2-entry in-order FIFO; a handshake occurs when p1_valid and p1_ready are both 1.
REQ-014 SHALL drive p1_ready = (FIFO count < 2), computed from the current count and independent of a same-cycle pop.
REQ-015 SHALL accept a port-1 request with p1_addr==0 without enqueueing it or issuing any write.
REQ-016 SHALL treat a port-0 request with p0_addr==0 as accepted when p0_ready=1, with no write issued and no grant consumed.
REQ-017 SHALL keep a wait counter that increments each cycle the FIFO is non-empty and its head is not popped, saturates at MAX_WAIT, and clears to 0 on any head pop.
REQ-018 SHALL assert force = (counter==MAX_WAIT) and (FIFO non-empty), combinationally; p1_starve = force and p0_ready = !force.
REQ-019 SHALL select the grant each cycle by priority: force -> FIFO head; else p0_valid with nonzero addr -> port 0; else FIFO non-empty -> FIFO head; else none.
REQ-020 SHALL pop the FIFO head only when it is granted.
REQ-021 SHALL never grant an entry in the same cycle it is pushed (no bypass), so minimum port-1 latency is 2 cycles from handshake to grf_we.
REQ-022 SHALL register the granted write on the next rising edge: grf_we=1 and addr/data/pc copied; with no grant, grf_we=0 and the other outputs hold their values.
REQ-023 SHALL allow push and pop in the same cycle, leaving the count unchanged.
REQ-024 SHALL keep a pending bit set while any remaining entry targets that register when two entries share an address.
REQ-025 SHALL keep grants in port-1 issue order; grants SHALL never be lost or duplicated.

Reset
REQ-026 SHALL, while reset=0, empty the FIFO, clear the counter, and drive grf_we=0, grf_a3=0, grf_wd=0, grf_wpc=0, pending=0, p1_starve=0, and p1_ready=1 and p0_ready=1 (FIFO empty, no force).
REQ-027 SHALL discard any queued entries on reset assertion mid-operation, with no write issued on release.

Configuration
REQ-028 SHALL compute pending from the FIFO contents per REQ-011 when GRF_ARB_SCOREBOARD_EN is defined.
REQ-029 SHALL tie pending to 0 and synthesize no scoreboard logic when GRF_ARB_SCOREBOARD_EN is not defined; all other behaviour is unchanged.

Structure
REQ-030 SHALL place the following in shared package grf_arb_pkg: a write-entry struct {addr[4:0], data[31:0], pc[31:0]}, constants ARB_DEPTH=2 and REG_ADDR_W=5, and a grant-source enum {NONE, P0, P1}.
REQ-031 SHALL implement the FIFO as sub-module grf_arb_fifo (push/pop/count/head, entry-array view for the scoreboard).

Verification
REQ-032 SHALL cover: p0 only, addr 5, data 0x1234, pc 0x3000 -> next cycle grf_we=1, a3=5, wd=0x1234, wpc=0x3000.
REQ-033 SHALL cover: p1 push addr 7, data 0xAA, p0 idle -> grf_we=1, a3=7 exactly 2 cycles after the handshake; pending[7] is 1 in between, then 0.
REQ-034 SHALL cover: p1 push addr 3, p0_valid held high with nonzero addr, MAX_WAIT=4 -> after 4 waiting cycles p1_starve=1 and p0_ready=0 for 1 cycle, then a3=3 written; p0 resumes next cycle.
REQ-035 SHALL cover: two p1 pushes with p0 busy -> p1_ready=0, and a third p1_valid is not accepted until a pop.
REQ-036 SHALL cover: p1 push addr 0 and p0 addr 0 -> both accepted, grf_we stays 0, pending stays 0.
REQ-037 SHALL cover: reset=0 with 2 entries queued -> all outputs at reset values, and no write appears after release.
